// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - PC redirect sequencing, stall vector and exception flush (optional stats: BRANCH_STAT_EN)
module branch_redirect_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_branch_flag,
  input  logic [ADDR_W-1:0] id_branch_addr,
  input  logic              stall_req_if,
  input  logic              stall_req_id,
  input  logic              stall_req_ex,
  input  logic              stall_req_mem,
  input  logic              exc_flag,
  input  logic [ADDR_W-1:0] exc_pc,
  output logic [STALL_W-1:0] stall,
  output logic              flush,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_redirect_addr,
  output logic              id_in_delay_slot,
  output logic              busy
`ifdef BRANCH_STAT_EN
  ,
  output logic [31:0]       stat_redirects,
  output logic [31:0]       stat_stall_cycles,
  output logic [15:0]       stat_pend_events
`endif
);

  typedef enum logic {IDLE, PEND} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              delay_q, delay_d;
  logic              accept;

  // Stall vector: the deepest requesting stage holds itself and everything upstream
  always_comb begin
    stall = '0;
    if (rst && !exc_flag) begin
      if (stall_req_mem)     stall = STALL_W'(6'b011111);
      else if (stall_req_ex) stall = STALL_W'(6'b001111);
      else if (stall_req_id) stall = STALL_W'(6'b000111);
      else if (stall_req_if) stall = STALL_W'(6'b000011);
    end
  end

  // Redirect/flush outputs and next-state; exception overrides any pending branch
  always_comb begin
    state_d          = state_q;
    pend_addr_d      = pend_addr_q;
    delay_d          = delay_q;
    flush            = 1'b0;
    pc_redirect      = 1'b0;
    pc_redirect_addr = '0;
    busy             = 1'b0;
    accept           = 1'b0;
    if (rst) begin
      accept = (state_q == IDLE) && id_valid && id_branch_flag && !stall[2] && !exc_flag;
      busy   = (state_q == PEND);
      if (exc_flag) begin
        flush            = 1'b1;
        pc_redirect      = 1'b1;
        pc_redirect_addr = exc_pc;
        state_d          = IDLE;
        delay_d          = 1'b0;
      end else begin
        if (state_q == PEND) begin
          pc_redirect_addr = pend_addr_q;
          pc_redirect      = !stall[0];
          if (!stall[0]) state_d = IDLE;
        end else if (accept) begin
          if (stall[0]) begin
            pend_addr_d = id_branch_addr;
            state_d     = PEND;
          end else begin
            pc_redirect      = 1'b1;
            pc_redirect_addr = id_branch_addr;
          end
        end
        // The delay slot is the instruction after the branch; it owns the flag until it leaves ID
        if (accept)                                   delay_d = 1'b1;
        else if (delay_q && !stall[2] && id_valid)    delay_d = 1'b0;
      end
    end
  end

  assign id_in_delay_slot = rst & delay_q;

  // State, pending target and delay-slot flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pend_addr_q <= '0;
      delay_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      delay_q     <= delay_d;
    end
  end

`ifdef BRANCH_STAT_EN
  logic [31:0] redirects_q, stall_cycles_q;
  logic [15:0] pend_events_q;

  // Event counters; exception cycles are not attributed to branch activity
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirects_q    <= '0;
      stall_cycles_q <= '0;
      pend_events_q  <= '0;
    end else if (!exc_flag) begin
      if (pc_redirect)                               redirects_q    <= redirects_q + 32'd1;
      if (stall[0])                                  stall_cycles_q <= stall_cycles_q + 32'd1;
      if (state_q == IDLE && state_d == PEND)        pend_events_q  <= pend_events_q + 16'd1;
    end
  end

  assign stat_redirects    = redirects_q;
  assign stat_stall_cycles = stall_cycles_q;
  assign stat_pend_events  = pend_events_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - directed self-checking bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid, id_branch_flag;
  logic [31:0] id_branch_addr;
  logic        stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
  logic        exc_flag;
  logic [31:0] exc_pc;
  logic [5:0]  stall;
  logic        flush, pc_redirect, id_in_delay_slot, busy;
  logic [31:0] pc_redirect_addr;
`ifdef BRANCH_STAT_EN
  logic [31:0] stat_redirects, stat_stall_cycles;
  logic [15:0] stat_pend_events;
`endif

  int checks = 0;
  int errors = 0;

  branch_redirect_ctrl #(.ADDR_W(32), .STALL_W(6)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_branch_flag(id_branch_flag), .id_branch_addr(id_branch_addr),
    .stall_req_if(stall_req_if), .stall_req_id(stall_req_id),
    .stall_req_ex(stall_req_ex), .stall_req_mem(stall_req_mem),
    .exc_flag(exc_flag), .exc_pc(exc_pc),
    .stall(stall), .flush(flush), .pc_redirect(pc_redirect),
    .pc_redirect_addr(pc_redirect_addr), .id_in_delay_slot(id_in_delay_slot), .busy(busy)
`ifdef BRANCH_STAT_EN
    , .stat_redirects(stat_redirects), .stat_stall_cycles(stat_stall_cycles),
    .stat_pend_events(stat_pend_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_branch_flag = 0; id_branch_addr = 0;
    stall_req_if = 0; stall_req_id = 0; stall_req_ex = 0; stall_req_mem = 0;
    exc_flag = 0; exc_pc = 0;
  endtask

  task automatic branch(input logic [31:0] a);
    id_valid = 1; id_branch_flag = 1; id_branch_addr = a;
  endtask

  task automatic slot();
    id_valid = 1; id_branch_flag = 0; id_branch_addr = 32'hDEAD_0000;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
    check("redir_vs_stall0", {31'd0, pc_redirect & stall[0]}, 32'd0);
  endtask

  initial begin
    // Reset with busy inputs: every output must read zero
    rst = 0; idle_inputs();
    branch(32'h1111_2222); stall_req_if = 1; stall_req_mem = 1; exc_flag = 1; exc_pc = 32'h5555_AAAA;
    #2;
    check("rst_stall", {26'd0, stall}, 0);
    check("rst_flush", {31'd0, flush}, 0);
    check("rst_redir", {31'd0, pc_redirect}, 0);
    check("rst_addr", pc_redirect_addr, 0);
    check("rst_dslot", {31'd0, id_in_delay_slot}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    tick();
    rst = 1; idle_inputs(); settle();
    check("post_rst_stall", {26'd0, stall}, 0);
    check("post_rst_redir", {31'd0, pc_redirect}, 0);
    tick();

    // Plain branch: same-cycle redirect, delay slot flagged for one ID advance
    branch(32'h0000_1040); settle();
    check("br_redir", {31'd0, pc_redirect}, 1);
    check("br_addr", pc_redirect_addr, 32'h0000_1040);
    check("br_busy", {31'd0, busy}, 0);
    tick();
    slot(); settle();
    check("br_dslot", {31'd0, id_in_delay_slot}, 1);
    check("br_slot_noredir", {31'd0, pc_redirect}, 0);
    tick();
    idle_inputs(); settle();
    check("br_dslot_clr", {31'd0, id_in_delay_slot}, 0);
    tick();

    // Fetch stall: accept into PEND, hold 3 cycles, redirect when fetch frees
    branch(32'h0000_2000); stall_req_if = 1; settle();
    check("fs_stall", {26'd0, stall}, 32'h03);
    check("fs_acc_noredir", {31'd0, pc_redirect}, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 1) branch(32'hDEAD_BEEF); else slot();
      stall_req_if = 1; settle();
      check("fs_pend_busy", {31'd0, busy}, 1);
      check("fs_pend_noredir", {31'd0, pc_redirect}, 0);
      check("fs_pend_addr", pc_redirect_addr, 32'h0000_2000);
      if (i == 0) check("fs_dslot", {31'd0, id_in_delay_slot}, 1);
      tick();
    end
    idle_inputs(); settle();
    check("fs_redir", {31'd0, pc_redirect}, 1);
    check("fs_redir_addr", pc_redirect_addr, 32'h0000_2000);
    tick();
    settle();
    check("fs_done_busy", {31'd0, busy}, 0);
    check("fs_done_redir", {31'd0, pc_redirect}, 0);
    tick();

    // Stall priority and branch held off by ID stall
    stall_req_ex = 1; settle();
    check("prio_ex", {26'd0, stall}, 32'h0F);
    tick();
    idle_inputs(); branch(32'h0000_4000); stall_req_id = 1; stall_req_mem = 1; settle();
    check("prio_mem", {26'd0, stall}, 32'h1F);
    check("prio_noacc", {31'd0, pc_redirect}, 0);
    tick();
    stall_req_mem = 0; settle();
    check("prio_id", {26'd0, stall}, 32'h07);
    check("prio_id_noacc", {31'd0, pc_redirect}, 0);
    tick();
    settle();
    check("prio_id_dslot", {31'd0, id_in_delay_slot}, 0);
    stall_req_id = 0; settle();
    check("prio_acc", {31'd0, pc_redirect}, 1);
    check("prio_acc_addr", pc_redirect_addr, 32'h0000_4000);
    tick();
    idle_inputs(); settle();
    check("dslot_hold_novalid", {31'd0, id_in_delay_slot}, 1);
    tick();
    slot(); stall_req_ex = 1; settle();
    check("dslot_hold_stall", {31'd0, id_in_delay_slot}, 1);
    tick();
    stall_req_ex = 0; tick();
    idle_inputs(); settle();
    check("dslot_clr2", {31'd0, id_in_delay_slot}, 0);
    tick();

    // Exception during PEND wins and discards the pending target
    branch(32'h0000_3000); stall_req_if = 1; tick();
    slot(); stall_req_if = 1; settle();
    check("exc_pend_busy", {31'd0, busy}, 1);
    exc_flag = 1; exc_pc = 32'hBFC0_0380; settle();
    check("exc_flush", {31'd0, flush}, 1);
    check("exc_redir", {31'd0, pc_redirect}, 1);
    check("exc_addr", pc_redirect_addr, 32'hBFC0_0380);
    check("exc_stall", {26'd0, stall}, 0);
    tick();
    idle_inputs(); settle();
    check("exc_after_busy", {31'd0, busy}, 0);
    check("exc_after_redir", {31'd0, pc_redirect}, 0);
    check("exc_after_flush", {31'd0, flush}, 0);
    tick();

    // Exception with a branch in ID: branch dropped, no delay slot
    branch(32'h0000_5000); exc_flag = 1; exc_pc = 32'h8000_0180; settle();
    check("excbr_addr", pc_redirect_addr, 32'h8000_0180);
    tick();
    idle_inputs(); settle();
    check("excbr_dslot", {31'd0, id_in_delay_slot}, 0);
    check("excbr_busy", {31'd0, busy}, 0);
    tick();

    // Reset while PEND drops the pending redirect
    branch(32'h0000_6000); stall_req_if = 1; tick();
    idle_inputs(); #2; rst = 0; #2; rst = 1; settle();
    check("rstpend_busy", {31'd0, busy}, 0);
    check("rstpend_redir", {31'd0, pc_redirect}, 0);
    tick();

`ifdef BRANCH_STAT_EN
    rst = 0; #2; rst = 1; tick();
    for (int b = 0; b < 5; b++) begin
      branch(32'h0000_7000 + b * 32'h10);
      stall_req_if = (b == 1 || b == 3);
      tick();
      if (b == 1 || b == 3) begin
        slot(); stall_req_if = 1; tick();
        stall_req_if = 0; tick();
      end
      idle_inputs(); slot(); tick();
      idle_inputs(); tick();
    end
    check("stat_redirects", stat_redirects, 5);
    check("stat_pend", {16'd0, stat_pend_events}, 2);
    check("stat_stall", stat_stall_cycles, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
